// File: rtl/led_mm_arbiter.sv
// Two-master round-robin arbiter in front of the LED blinker Avalon-MM slave.
// One transaction in flight; reads complete on readdatavalid or on a timeout.
module led_mm_arbiter #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                TIMEOUT_CYC = 16,
    parameter logic [DATA_W-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*ADDR_W-1:0] m_address,
    input  logic [1:0]          m_read,
    input  logic [1:0]          m_write,
    input  logic [2*DATA_W-1:0] m_writedata,
    output logic [1:0]          m_waitrequest,
    output logic [2*DATA_W-1:0] m_readdata,
    output logic [1:0]          m_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,
    output logic                busy,
    output logic                timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_RDWAIT = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]          rdv_q, rdv_d;
    logic                terr_q, terr_d;

    logic [1:0] req;
    logic       g_wr, g_rd, issue, fin_ok, fin_err;

    // Write wins when a master raises both commands.
    assign req   = m_read | m_write;
    assign g_wr  = m_write[grant_q];
    assign g_rd  = m_read[grant_q] & ~g_wr;
    assign issue = (state_q == S_ISSUE);

    assign s_address   = grant_q ? m_address[ADDR_W +: ADDR_W] : m_address[0 +: ADDR_W];
    assign s_writedata = grant_q ? m_writedata[DATA_W +: DATA_W] : m_writedata[0 +: DATA_W];
    assign s_read      = issue & g_rd;
    assign s_write     = issue & g_wr;
    assign busy        = (state_q != S_IDLE);

    assign m_readdata      = rdata_q;
    assign m_readdatavalid = rdv_q;
    assign timeout_err     = terr_q;

    always_comb begin
        m_waitrequest = 2'b11;
        if (issue) m_waitrequest[grant_q] = s_waitrequest;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rdv_d   = 2'b00;
        terr_d  = 1'b0;
        fin_ok  = 1'b0;
        fin_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = (req == 2'b11) ? ~last_q : req[1];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = '0;
                if (!s_waitrequest && g_wr) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end else if (!s_waitrequest && g_rd) begin
                    state_d = S_RDWAIT;
                    fin_ok  = s_readdatavalid;
                end else if (!g_wr && !g_rd) begin
                    // Request withdrawn mid-transfer: park in RD_WAIT so the timeout recovers.
                    state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (s_readdatavalid)        fin_ok  = 1'b1;
                else if (cnt_q == CNT_LAST) fin_err = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (fin_ok || fin_err) begin
            state_d        = S_IDLE;
            last_d         = grant_q;
            rdv_d[grant_q] = 1'b1;
            terr_d         = fin_err;
            if (grant_q) rdata_d[DATA_W +: DATA_W] = fin_err ? ERR_DATA : s_readdata;
            else         rdata_d[0 +: DATA_W]      = fin_err ? ERR_DATA : s_readdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rdata_q <= '0;
            rdv_q   <= 2'b00;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rdv_q   <= rdv_d;
            terr_q  <= terr_d;
        end
    end

endmodule

// File: doc/led_mm_arbiter.md
Name: led_mm_arbiter

Overview:
Two-master round-robin arbiter sharing one Avalon-MM slave, the LED blinker register block. Typical masters are the host bridge and an on-chip pattern sequencer, both writing LED enable and test registers. One transaction is outstanding at a time; reads wait for slave readdatavalid, bounded by a timeout so a silent slave cannot hang either master.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYC, 16, max cycles in RD_WAIT before error completion (>=2)
ERR_DATA, 32'hDEAD_BEEF, readdata returned on timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
m_address  in  2*ADDR_W  master i address at [i*ADDR_W +: ADDR_W]
m_read  in  2  per-master read request
m_write  in  2  per-master write request
m_writedata  in  2*DATA_W  master i write data at [i*DATA_W +: DATA_W]
m_waitrequest  out  2  per-master waitrequest
m_readdata  out  2*DATA_W  master i read data
m_readdatavalid  out  2  per-master read data valid
s_address  out  ADDR_W  slave address
s_read  out  1  slave read
s_write  out  1  slave write
s_writedata  out  DATA_W  slave write data
s_waitrequest  in  1  slave waitrequest
s_readdata  in  DATA_W  slave read data
s_readdatavalid  in  1  slave read data valid
busy  out  1  state != IDLE
timeout_err  out  1  one-cycle pulse on read timeout

Behaviour:
- Reset (async, rst=0): state IDLE, grant=0, last_grant=1 (master 0 wins first), m_waitrequest=2'b11, m_readdatavalid=0, m_readdata=0, timeout_err=0, timeout counter=0. s_read, s_write, busy are 0 combinationally.
- Master i requests when m_read[i] or m_write[i] is high. It holds address, data and command stable until m_waitrequest[i] is low (Avalon rule).
- If read and write are both high on one master, the write wins and the read is ignored.
- States:
  - IDLE: no slave command. If any request: single requester gets the grant; if both request, the master != last_grant wins. Registers grant, moves to ISSUE next cycle. Arbitration latency is 1 cycle.
  - ISSUE: s_address, s_writedata, s_read, s_write are muxed combinationally from master grant. m_waitrequest[grant] = s_waitrequest; the other master's bit stays 1.
    - On s_waitrequest=0 with a write: last_grant<=grant, go to IDLE.
    - On s_waitrequest=0 with a read: go to RD_WAIT, counter cleared. If s_readdatavalid=1 in the same cycle, complete as in RD_WAIT and go directly to IDLE.
  - RD_WAIT: s_read=s_write=0, both m_waitrequest=1, counter increments each cycle.
    - On s_readdatavalid=1: m_readdata[grant]<=s_readdata and m_readdatavalid[grant]<=1 next cycle (1-cycle registered), last_grant<=grant, go to IDLE.
    - When counter reaches TIMEOUT_CYC-1 with no valid: m_readdata[grant]<=ERR_DATA, m_readdatavalid[grant]<=1, timeout_err<=1, last_grant<=grant, go to IDLE.
- m_readdatavalid and timeout_err are single-cycle pulses. m_readdata of each master holds its last value otherwise.
- s_readdatavalid outside RD_WAIT/ISSUE-read is ignored, including late data after a timeout and data arriving in IDLE.
- Write transaction minimum: 2 cycles from request to m_waitrequest low (IDLE + ISSUE). Back-to-back grants are separated by one IDLE cycle.
- A request withdrawn in IDLE is legal. Withdrawal in ISSUE or RD_WAIT is a protocol violation; behaviour is undefined, but the FSM must still return to IDLE via the timeout.
- Reset asserted mid-transaction aborts immediately to reset values; no completion is delivered for the aborted read.

Test Plan:
- m0 write addr 0 data 1, s_waitrequest=0 -> s_write=1, s_address=0, s_writedata=1 in cycle 2; m_waitrequest[0]=0 same cycle; busy back to 0 in cycle 3.
- m0 and m1 both write immediately after reset, requests held -> m0 granted first, m1 second; with both kept requesting continuously, grants alternate 0,1,0,1 over 4 transactions.
- m1 read addr 1, slave accepts after 2 waitrequest cycles, readdatavalid 3 cycles later with 0x1234_5678 -> m_readdata[1]=0x1234_5678, m_readdatavalid=2'b10 exactly one cycle later; m0 sees no valid.
- m0 read, slave never returns valid, TIMEOUT_CYC=16 -> after 16 RD_WAIT cycles m_readdata[0]=0xDEAD_BEEF, m_readdatavalid[0] and timeout_err pulse once; a later s_readdatavalid is ignored.
- Zero-latency slave (readdatavalid=1 same cycle as accept) for m0 read of 0xA5 -> m_readdatavalid[0] next cycle with 0xA5, FSM in IDLE.
- rst low during RD_WAIT -> all outputs at reset values asynchronously; after release, a pending m1 read is serviced normally, and m0 has priority on a simultaneous request.
